// File: rtl/fft8_bfly_sched.sv
// fft8_bfly_sched: address/enable sequencer for one shared radix-2 butterfly
// running an 8-point in-place DIT FFT. Owns no data.
//   clk, rst          clock, synchronous active-high reset
//   start             begin a transform (IDLE only)
//   in_valid/in_ready load handshake; ld_we/ld_addr write samples bit-reversed
//   bf_rd_en, bf_addr_a/b, bf_tw_idx  butterfly issue (one per COMPUTE cycle)
//   bf_wr_en, bf_wr_addr_a/b          write-back, BFLY_LAT cycles after issue
//   stage, busy, done                 status
module fft8_bfly_sched #(
   parameter int BFLY_LAT = 2   // read-to-writeback latency, 1..7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       ld_we,
   output logic [2:0] ld_addr,
   output logic       bf_rd_en,
   output logic [2:0] bf_addr_a,
   output logic [2:0] bf_addr_b,
   output logic [1:0] bf_tw_idx,
   output logic       bf_wr_en,
   output logic [2:0] bf_wr_addr_a,
   output logic [2:0] bf_wr_addr_b,
   output logic [1:0] stage,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FLUSH, DONE} state_t;

   state_t     st, st_nx;
   logic [2:0] n;      // load count
   logic [1:0] j;      // butterfly index within stage
   logic [1:0] stg;    // stage counter
   logic [2:0] fcnt;   // flush cycle counter
   logic       last_flush;

   assign last_flush = (st == FLUSH) && (fcnt == 3'(BFLY_LAT - 1));

   // ---------------- next state ----------------
   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    if (start) st_nx = LOAD;
         LOAD:    if (in_valid && n == 3'd7) st_nx = COMPUTE;
         COMPUTE: if (j == 2'd3) st_nx = FLUSH;
         FLUSH:   if (last_flush) st_nx = (stg == 2'd2) ? DONE : COMPUTE;
         DONE:    st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st   <= IDLE;
         n    <= '0;
         j    <= '0;
         stg  <= '0;
         fcnt <= '0;
      end else begin
         st <= st_nx;
         case (st)
            IDLE: begin
               n   <= '0;
               j   <= '0;
               stg <= '0;
            end
            LOAD:    if (in_valid) n <= n + 3'd1;
            COMPUTE: begin
               j    <= j + 2'd1;   // wraps to 0 after j=3, ready for next stage
               fcnt <= '0;
            end
            FLUSH: begin
               fcnt <= fcnt + 3'd1;
               if (last_flush) begin
                  fcnt <= '0;
                  if (stg != 2'd2) stg <= stg + 2'd1;
               end
            end
            DONE:    stg <= '0;
            default: ;
         endcase
      end
   end

   // ---------------- load side ----------------
   assign in_ready = (st == LOAD);
   assign ld_we    = in_valid & in_ready;
   assign ld_addr  = ld_we ? {n[0], n[1], n[2]} : 3'd0;

   // ---------------- butterfly addressing ----------------
   // a = grp*2*span + pos, b = a + span, k = pos << (2-stage)
   logic [2:0] span, addr_a;
   logic [1:0] pos, grp;

   assign span   = 3'd1 << stg;
   assign pos    = j & 2'(span - 3'd1);
   assign grp    = j >> stg;
   assign addr_a = (({1'b0, grp} << stg) << 1) | {1'b0, pos};

   assign bf_rd_en  = (st == COMPUTE);
   assign bf_addr_a = bf_rd_en ? addr_a : 3'd0;
   assign bf_addr_b = bf_rd_en ? addr_a + span : 3'd0;
   assign bf_tw_idx = bf_rd_en ? 2'(pos << (2'd2 - stg)) : 2'd0;

   // ---------------- write-back delay line ----------------
   // Addresses shift along with the valid bit; idle slots carry zero so the
   // write address outputs stay 0 whenever bf_wr_en is low.
   logic       vld_pipe [BFLY_LAT];
   logic [2:0] wa_pipe  [BFLY_LAT];
   logic [2:0] wb_pipe  [BFLY_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BFLY_LAT; i++) begin
            vld_pipe[i] <= 1'b0;
            wa_pipe[i]  <= '0;
            wb_pipe[i]  <= '0;
         end
      end else begin
         vld_pipe[0] <= bf_rd_en;
         wa_pipe[0]  <= bf_addr_a;
         wb_pipe[0]  <= bf_addr_b;
         for (int i = 1; i < BFLY_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            wa_pipe[i]  <= wa_pipe[i-1];
            wb_pipe[i]  <= wb_pipe[i-1];
         end
      end
   end

   assign bf_wr_en     = vld_pipe[BFLY_LAT-1];
   assign bf_wr_addr_a = wa_pipe[BFLY_LAT-1];
   assign bf_wr_addr_b = wb_pipe[BFLY_LAT-1];

   // ---------------- status ----------------
   assign stage = (st == COMPUTE || st == FLUSH) ? stg : 2'd0;
   assign busy  = (st != IDLE);
   assign done  = (st == DONE);

endmodule
